dfi_phy_resp: RTL and testbench

- PHY-side responder for the DDR2 controller's DFI: consumes the control, write and read channels and sources read data.
- Decodes DFI commands and tracks the open row of each bank.
- Captures masked write data into a small register store and returns read data after a fixed PHY read latency.
- Serves as the synthesizable far end for controller bring-up and loopback, and flags protocol violations.

---
 rtl/dfi_phy_resp_pkg.sv | 51 +++++
 rtl/dfi_phy_resp_if.sv | 37 +++
 rtl/dfi_phy_resp_q.sv | 55 +++++
 rtl/dfi_phy_resp.sv | 187 ++++++++++++++++++
 tb/tb_dfi_phy_resp.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dfi_phy_resp_pkg.sv
// Shared types for the DFI PHY-side responder: command and error encodings,
// pending-command queue entry and the command decoder.
package dfi_phy_resp_pkg;

  localparam int unsigned DataWidth = 128;
  localparam int unsigned NumLanes  = 8;
  localparam int unsigned LaneWidth = 16;
  localparam int unsigned QBaWidth  = 3;
  localparam int unsigned QColBits  = 4;

  typedef enum logic [2:0] {
    CmdNop,
    CmdAct,
    CmdRd,
    CmdWr,
    CmdPre,
    CmdRef,
    CmdBad
  } cmd_e;

  typedef enum logic [2:0] {
    ErrNone     = 3'd0,
    ErrActOpen  = 3'd1,
    ErrNotOpen  = 3'd2,
    ErrRefOpen  = 3'd3,
    ErrBadCmd   = 3'd4,
    ErrWrOrphan = 3'd5,
    ErrRdOrphan = 3'd6,
    ErrQOvf     = 3'd7
  } err_e;

  typedef struct packed {
    logic [QBaWidth-1:0] ba;
    logic [QColBits-1:0] col;
  } q_entry_t;

  function automatic cmd_e decode_cmd(input logic ras_n, input logic cas_n, input logic we_n);
    cmd_e cmd;
    case ({ras_n, cas_n, we_n})
      3'b111:  cmd = CmdNop;
      3'b011:  cmd = CmdAct;
      3'b101:  cmd = CmdRd;
      3'b100:  cmd = CmdWr;
      3'b010:  cmd = CmdPre;
      3'b001:  cmd = CmdRef;
      default: cmd = CmdBad;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/dfi_phy_resp_if.sv
// DFI control, write and read channels between the controller (master) and
// the PHY responder (slave).
interface dfi_phy_resp_if #(
  parameter int unsigned BA_WIDTH   = 3,
  parameter int unsigned ADDR_WIDTH = 14
);
  import dfi_phy_resp_pkg::*;

  logic                  cke;
  logic                  cs_n;
  logic                  ras_n;
  logic                  cas_n;
  logic                  we_n;
  logic [BA_WIDTH-1:0]   ba;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  odt;
  logic                  wrdata_en;
  logic [DataWidth-1:0]  wrdata;
  logic [NumLanes-1:0]   wrdata_mask;
  logic                  rddata_en;
  logic [DataWidth-1:0]  rddata;
  logic                  rddata_valid;
  logic [NumLanes-1:0]   rddata_dnv;

  modport master (
    output cke, cs_n, ras_n, cas_n, we_n, ba, addr, odt,
    output wrdata_en, wrdata, wrdata_mask, rddata_en,
    input  rddata, rddata_valid, rddata_dnv
  );

  modport slave (
    input  cke, cs_n, ras_n, cas_n, we_n, ba, addr, odt,
    input  wrdata_en, wrdata, wrdata_mask, rddata_en,
    output rddata, rddata_valid, rddata_dnv
  );

endinterface

// File: rtl/dfi_phy_resp_q.sv
// Synchronous FIFO for pending RD/WR commands; a push on a full queue is taken
// only when a pop happens in the same cycle.
module dfi_phy_resp_q #(
  parameter int unsigned Depth   = 4,
  parameter type         entry_t = logic
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  entry_t            mem_q [Depth];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [CntW-1:0]   cnt_q;
  logic              push_ok, pop_ok;

  function automatic logic [PtrW-1:0] incr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt_q == CntW'(Depth));
  assign empty   = (cnt_q == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign head    = mem_q[rptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= incr(wptr_q);
      if (pop_ok)  rptr_q <= incr(rptr_q);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= push_data;
  end

endmodule

// File: rtl/dfi_phy_resp.sv
// DFI PHY-side responder: decodes commands, tracks open banks, stores masked
// write bursts and returns read bursts after a fixed latency.
module dfi_phy_resp
  import dfi_phy_resp_pkg::*;
#(
  parameter int unsigned BA_WIDTH    = QBaWidth,
  parameter int unsigned ADDR_WIDTH  = 14,
  parameter int unsigned COL_BITS    = QColBits,
  parameter int unsigned BURST_BEATS = 2,
  parameter int unsigned RD_LAT      = 3,
  parameter int unsigned QDEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  dfi_phy_resp_if.slave              dfi,
  output logic                       err_valid,
  output logic [2:0]                 err_code,
  output logic [(1<<BA_WIDTH)-1:0]   bank_open
);

  localparam int unsigned NumBanks   = 1 << BA_WIDTH;
  localparam int unsigned IdxW       = BA_WIDTH + COL_BITS;
  localparam int unsigned NumEntries = 1 << IdxW;
  localparam int unsigned BeatW      = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(BURST_BEATS - 1);

  cmd_e                  cmd;
  logic                  cmd_valid;
  logic [NumBanks-1:0]   bank_open_q, bank_open_d;
  err_e                  cmd_err, wr_err, rd_err, err_d, err_q;
  q_entry_t              new_ent, rd_head, wr_head;
  logic                  rd_push, rd_pop, rd_full, rd_empty;
  logic                  wr_push, wr_pop, wr_full, wr_empty;
  logic                  rd_go, wr_go;
  logic [BeatW-1:0]      rd_beat_q, rd_beat_d, wr_beat_q, wr_beat_d;
  logic [IdxW-1:0]       rd_idx, wr_idx;
  logic [DataWidth-1:0]  store_q [NumEntries];
  logic [NumEntries-1:0] store_vld_q;
  logic [DataWidth-1:0]  rd_data;
  logic [NumLanes-1:0]   rd_dnv;
  logic [RD_LAT-1:0]     pipe_vld_q;
  logic [DataWidth-1:0]  pipe_data_q [RD_LAT];
  logic [NumLanes-1:0]   pipe_dnv_q [RD_LAT];
  logic                  unused_sig;

  assign cmd_valid   = dfi.cke & ~dfi.cs_n;
  assign cmd         = decode_cmd(dfi.ras_n, dfi.cas_n, dfi.we_n);
  assign new_ent.ba  = dfi.ba;
  assign new_ent.col = dfi.addr[COL_BITS-1:0];
  assign unused_sig  = ^{dfi.odt, dfi.addr};

  always_comb begin
    bank_open_d = bank_open_q;
    cmd_err     = ErrNone;
    rd_push     = 1'b0;
    wr_push     = 1'b0;
    if (cmd_valid) begin
      case (cmd)
        CmdAct: begin
          if (bank_open_q[dfi.ba]) cmd_err = ErrActOpen;
          bank_open_d[dfi.ba] = 1'b1;
        end
        CmdRd: begin
          if (bank_open_q[dfi.ba]) rd_push = 1'b1;
          else                     cmd_err = ErrNotOpen;
        end
        CmdWr: begin
          if (bank_open_q[dfi.ba]) wr_push = 1'b1;
          else                     cmd_err = ErrNotOpen;
        end
        CmdPre: begin
          if (dfi.addr[10]) bank_open_d = '0;
          else              bank_open_d[dfi.ba] = 1'b0;
        end
        CmdRef:  if (|bank_open_q) cmd_err = ErrRefOpen;
        CmdBad:  cmd_err = ErrBadCmd;
        default: ;
      endcase
    end
    // The queue itself refuses the push; here we only report the drop.
    if ((rd_push && rd_full && !rd_pop) || (wr_push && wr_full && !wr_pop)) cmd_err = ErrQOvf;
  end

  always_comb begin
    wr_go     = dfi.wrdata_en & ~wr_empty;
    wr_err    = (dfi.wrdata_en && wr_empty) ? ErrWrOrphan : ErrNone;
    wr_pop    = wr_go && (wr_beat_q == LastBeat);
    wr_beat_d = wr_beat_q;
    if (wr_go) wr_beat_d = wr_pop ? '0 : wr_beat_q + 1'b1;
    wr_idx    = {wr_head.ba, wr_head.col + COL_BITS'(wr_beat_q)};

    rd_go     = dfi.rddata_en & ~rd_empty;
    rd_err    = (dfi.rddata_en && rd_empty) ? ErrRdOrphan : ErrNone;
    rd_pop    = rd_go && (rd_beat_q == LastBeat);
    rd_beat_d = rd_beat_q;
    if (rd_go) rd_beat_d = rd_pop ? '0 : rd_beat_q + 1'b1;
    rd_idx    = {rd_head.ba, rd_head.col + COL_BITS'(rd_beat_q)};

    rd_data = '0;
    rd_dnv  = '0;
    if (rd_go) begin
      if (store_vld_q[rd_idx]) rd_data = store_q[rd_idx];
    end else if (dfi.rddata_en) begin
      rd_dnv = '1;
    end

    if (cmd_err != ErrNone)     err_d = cmd_err;
    else if (wr_err != ErrNone) err_d = wr_err;
    else                        err_d = rd_err;
  end

  dfi_phy_resp_q #(
    .Depth   (QDEPTH),
    .entry_t (q_entry_t)
  ) u_rd_q (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_push),
    .push_data (new_ent),
    .pop       (rd_pop),
    .head      (rd_head),
    .full      (rd_full),
    .empty     (rd_empty)
  );

  dfi_phy_resp_q #(
    .Depth   (QDEPTH),
    .entry_t (q_entry_t)
  ) u_wr_q (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_push),
    .push_data (new_ent),
    .pop       (wr_pop),
    .head      (wr_head),
    .full      (wr_full),
    .empty     (wr_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_open_q <= '0;
      err_q       <= ErrNone;
      wr_beat_q   <= '0;
      rd_beat_q   <= '0;
      store_vld_q <= '0;
      pipe_vld_q  <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_data_q[i] <= '0;
        pipe_dnv_q[i]  <= '0;
      end
    end else begin
      bank_open_q <= bank_open_d;
      err_q       <= err_d;
      wr_beat_q   <= wr_beat_d;
      rd_beat_q   <= rd_beat_d;
      if (wr_go) store_vld_q[wr_idx] <= 1'b1;
      pipe_vld_q[0]  <= dfi.rddata_en;
      pipe_data_q[0] <= rd_data;
      pipe_dnv_q[0]  <= rd_dnv;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_data_q[i] <= pipe_data_q[i-1];
        pipe_dnv_q[i]  <= pipe_dnv_q[i-1];
      end
    end
  end

  // Store contents are deliberately not reset; the valid bits gate readback.
  always_ff @(posedge clk) begin
    if (wr_go) begin
      for (int l = 0; l < NumLanes; l++) begin
        if (!dfi.wrdata_mask[l]) begin
          store_q[wr_idx][l*LaneWidth +: LaneWidth] <= dfi.wrdata[l*LaneWidth +: LaneWidth];
        end
      end
    end
  end

  assign dfi.rddata       = pipe_data_q[RD_LAT-1];
  assign dfi.rddata_valid = pipe_vld_q[RD_LAT-1];
  assign dfi.rddata_dnv   = pipe_dnv_q[RD_LAT-1];
  assign err_valid        = (err_q != ErrNone);
  assign err_code         = err_q;
  assign bank_open        = bank_open_q;

endmodule

// File: tb/tb_dfi_phy_resp.sv
// Scoreboard bench for dfi_phy_resp: the driver queues expected read beats and
// error pulses with their due cycle; a negedge monitor pops and compares them.
module tb_dfi_phy_resp;
  import dfi_phy_resp_pkg::*;

  localparam int unsigned RdLat = 3;
  localparam logic [2:0] EncNop = 3'b111, EncAct = 3'b011, EncRd = 3'b101;
  localparam logic [2:0] EncWr = 3'b100, EncPre = 3'b010, EncRef = 3'b001, EncBad = 3'b000;

  logic       clk = 1'b0;
  logic       rst;
  logic       err_valid;
  logic [2:0] err_code;
  logic [7:0] bank_open;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    logic [127:0] data;
    logic [7:0]   dnv;
    int           due;
  } rd_exp_t;

  typedef struct {
    logic [2:0] code;
    int         due;
  } err_exp_t;

  rd_exp_t  rd_q[$];
  err_exp_t err_q[$];

  dfi_phy_resp_if #(.BA_WIDTH(3), .ADDR_WIDTH(14)) dfi ();

  dfi_phy_resp #(
    .BA_WIDTH    (3),
    .ADDR_WIDTH  (14),
    .COL_BITS    (4),
    .BURST_BEATS (2),
    .RD_LAT      (RdLat),
    .QDEPTH      (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .dfi       (dfi),
    .err_valid (err_valid),
    .err_code  (err_code),
    .bank_open (bank_open)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every presented beat / error pulse must match the queue head.
  always @(negedge clk) begin
    rd_exp_t  re;
    err_exp_t ee;
    if (dfi.rddata_valid) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_beat: unexpected beat at cycle %0d data %h dnv %h, required none",
                 cyc, dfi.rddata, dfi.rddata_dnv);
      end else begin
        re = rd_q.pop_front();
        if (dfi.rddata !== re.data || dfi.rddata_dnv !== re.dnv || cyc != re.due) begin
          errors++;
          $display("FAIL rd_beat: got data %h dnv %h cycle %0d, required data %h dnv %h cycle %0d",
                   dfi.rddata, dfi.rddata_dnv, cyc, re.data, re.dnv, re.due);
        end
      end
    end
    if (err_valid) begin
      checks++;
      if (err_q.size() == 0) begin
        errors++;
        $display("FAIL err_pulse: unexpected code %0d at cycle %0d, required none", err_code, cyc);
      end else begin
        ee = err_q.pop_front();
        if (err_code !== ee.code || cyc != ee.due) begin
          errors++;
          $display("FAIL err_pulse: got code %0d cycle %0d, required code %0d cycle %0d",
                   err_code, cyc, ee.code, ee.due);
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    dfi.cke         = 1'b1;
    dfi.cs_n        = 1'b0;
    {dfi.ras_n, dfi.cas_n, dfi.we_n} = EncNop;
    dfi.ba          = '0;
    dfi.addr        = '0;
    dfi.odt         = 1'b0;
    dfi.wrdata_en   = 1'b0;
    dfi.wrdata      = '0;
    dfi.wrdata_mask = '0;
    dfi.rddata_en   = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic expect_err(input logic [2:0] code);
    err_exp_t e;
    if (code != 3'd0) begin
      e.code = code;
      e.due  = cyc + 1;
      err_q.push_back(e);
    end
  endtask

  task automatic expect_rd(input logic [127:0] data, input logic [7:0] dnv);
    rd_exp_t e;
    e.data = data;
    e.dnv  = dnv;
    e.due  = cyc + RdLat;
    rd_q.push_back(e);
  endtask

  task automatic cmd(input logic [2:0] enc, input logic [2:0] ba, input logic [13:0] addr,
                     input logic [2:0] exp_err);
    {dfi.ras_n, dfi.cas_n, dfi.we_n} = enc;
    dfi.ba   = ba;
    dfi.addr = addr;
    expect_err(exp_err);
    step();
  endtask

  task automatic wr_beat(input logic [127:0] data, input logic [7:0] mask,
                         input logic [2:0] exp_err);
    dfi.wrdata_en   = 1'b1;
    dfi.wrdata      = data;
    dfi.wrdata_mask = mask;
    expect_err(exp_err);
    step();
  endtask

  task automatic rd_beat(input logic [127:0] data, input logic [7:0] dnv,
                         input logic [2:0] exp_err);
    dfi.rddata_en = 1'b1;
    expect_rd(data, dnv);
    expect_err(exp_err);
    step();
  endtask

  // Pattern for write pair p, beat b: every byte equals 0xA0 + 2p + b.
  function automatic logic [127:0] pv(input int p, input int b);
    logic [7:0] v;
    v = 8'hA0 + 8'(2 * p + b);
    return {16{v}};
  endfunction

  localparam logic [127:0] DatA = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] DatB = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] DatC = {8{16'hC0DE}};
  localparam logic [127:0] DatD = {8{16'hD00D}};
  localparam logic [127:0] Ones = {128{1'b1}};
  localparam logic [127:0] Lane0 = {112'h0, 16'hFFFF};
  localparam logic [127:0] NewW0 = {16{8'h5A}};
  localparam logic [127:0] NewW1 = {16{8'hA5}};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rddata_valid", dfi.rddata_valid, 0);
    check("rst_rddata", dfi.rddata, 0);
    check("rst_dnv", dfi.rddata_dnv, 0);
    check("rst_err_valid", err_valid, 0);
    check("rst_bank_open", bank_open, 0);
    rst = 1'b0;
    step();

    // Basic burst write then read back.
    cmd(EncAct, 3'd2, 14'h55, 3'd0);
    check("bank_open_act2", bank_open, 8'h04);
    cmd(EncWr, 3'd2, 14'h3, 3'd0);
    wr_beat(DatA, 8'h00, 3'd0);
    wr_beat(DatB, 8'h00, 3'd0);
    cmd(EncRd, 3'd2, 14'h3, 3'd0);
    rd_beat(DatA, 8'h00, 3'd0);
    rd_beat(DatB, 8'h00, 3'd0);

    // Lane masking: masked lanes keep their previous contents.
    cmd(EncWr, 3'd2, 14'h8, 3'd0);
    wr_beat(Ones, 8'h00, 3'd0);
    wr_beat(Ones, 8'h00, 3'd0);
    cmd(EncWr, 3'd2, 14'h8, 3'd0);
    wr_beat('0, 8'h01, 3'd0);
    wr_beat('0, 8'hFF, 3'd0);
    cmd(EncRd, 3'd2, 14'h8, 3'd0);
    rd_beat(Lane0, 8'h00, 3'd0);
    rd_beat(Ones, 8'h00, 3'd0);

    // Closed bank and orphan read.
    cmd(EncRd, 3'd5, 14'h0, 3'd2);
    rd_beat('0, 8'hFF, 3'd6);

    // Column wrap within a burst on write and read; unwritten entry.
    cmd(EncWr, 3'd2, 14'hF, 3'd0);
    wr_beat(DatC, 8'h00, 3'd0);
    wr_beat(DatD, 8'h00, 3'd0);
    cmd(EncRd, 3'd2, 14'hF, 3'd0);
    rd_beat(DatC, 8'h00, 3'd0);
    rd_beat(DatD, 8'h00, 3'd0);
    cmd(EncRd, 3'd2, 14'h0, 3'd0);
    rd_beat(DatD, 8'h00, 3'd0);
    rd_beat('0, 8'h00, 3'd0);

    // Bank bookkeeping, refresh rules and illegal encodings.
    cmd(EncAct, 3'd0, 14'h11, 3'd0);
    cmd(EncAct, 3'd1, 14'h22, 3'd0);
    check("bank_open_012", bank_open, 8'h07);
    cmd(EncRef, 3'd0, 14'h0, 3'd3);
    cmd(EncAct, 3'd0, 14'h12, 3'd1);
    cmd(EncBad, 3'd0, 14'h0, 3'd4);
    dfi.cke = 1'b0;
    {dfi.ras_n, dfi.cas_n, dfi.we_n} = EncBad;
    step();
    dfi.cs_n = 1'b1;
    {dfi.ras_n, dfi.cas_n, dfi.we_n} = EncRef;
    step();
    cmd(EncPre, 3'd0, 14'h0400, 3'd0);
    check("bank_open_preall", bank_open, 8'h00);
    cmd(EncRef, 3'd0, 14'h0, 3'd0);
    cmd(EncAct, 3'd3, 14'h1, 3'd0);
    cmd(EncAct, 3'd4, 14'h2, 3'd0);
    cmd(EncPre, 3'd3, 14'h0, 3'd0);
    check("bank_open_pre3", bank_open, 8'h10);
    cmd(EncPre, 3'd3, 14'h0, 3'd0);
    cmd(EncPre, 3'd4, 14'h0400, 3'd0);
    check("bank_open_closed", bank_open, 8'h00);

    // Write queue overflow and orphan write beats.
    cmd(EncAct, 3'd1, 14'h33, 3'd0);
    for (int p = 0; p < 4; p++) cmd(EncWr, 3'd1, 14'(2 * p), 3'd0);
    cmd(EncWr, 3'd1, 14'h8, 3'd7);
    for (int p = 0; p < 5; p++) begin
      wr_beat(pv(p, 0), 8'h00, (p == 4) ? 3'd5 : 3'd0);
      wr_beat(pv(p, 1), 8'h00, (p == 4) ? 3'd5 : 3'd0);
    end
    cmd(EncRd, 3'd1, 14'h0, 3'd0);
    rd_beat(pv(0, 0), 8'h00, 3'd0);
    rd_beat(pv(0, 1), 8'h00, 3'd0);
    cmd(EncRd, 3'd1, 14'h6, 3'd0);
    rd_beat(pv(3, 0), 8'h00, 3'd0);
    rd_beat(pv(3, 1), 8'h00, 3'd0);
    cmd(EncRd, 3'd1, 14'h8, 3'd0);
    rd_beat('0, 8'h00, 3'd0);
    rd_beat('0, 8'h00, 3'd0);

    // Same-cycle write and read of one index: read sees pre-edge data.
    cmd(EncWr, 3'd1, 14'h0, 3'd0);
    cmd(EncRd, 3'd1, 14'h0, 3'd0);
    for (int b = 0; b < 2; b++) begin
      dfi.wrdata_en = 1'b1;
      dfi.wrdata    = (b == 0) ? NewW0 : NewW1;
      dfi.rddata_en = 1'b1;
      expect_rd(pv(0, b), 8'h00);
      step();
    end
    cmd(EncRd, 3'd1, 14'h0, 3'd0);
    rd_beat(NewW0, 8'h00, 3'd0);
    rd_beat(NewW1, 8'h00, 3'd0);

    // Reset while a read beat is about to emerge: it must vanish.
    cmd(EncRd, 3'd1, 14'h0, 3'd0);
    dfi.rddata_en = 1'b1;
    step();
    step();
    @(posedge clk);
    #1;
    check("pending_valid", dfi.rddata_valid, 1);
    rst = 1'b1;
    #1;
    check("rst_kills_valid", dfi.rddata_valid, 0);
    check("rst_bank_open_mid", bank_open, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) step();

    check("sb_rd_drained", rd_q.size(), 0);
    check("sb_err_drained", err_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
